icache_axi_refill_unit: RTL

ICACHE_AXI_REFILL_UNIT -- requirements
Module: icache_axi_refill_unit

---
 rtl/icache_axi_refill_unit.sv | 156 +++++++++++++++
 1 files changed

// File: rtl/icache_axi_refill_unit.sv
// I-cache refill engine: turns miss requests into AXI read bursts and assembles
// the returned beats into cache lines, tracking up to NumSlots outstanding refills by AXI id.
module icache_axi_refill_unit #(
    parameter int unsigned DataWidth = 64,
    parameter int unsigned LineWidth = 128,
    parameter int unsigned NumSlots  = 2,
    parameter int unsigned PlenWidth = 56,
    parameter int unsigned TidWidth  = 2
) (
    input  logic                 clk_i,
    input  logic                 rst_i,

    input  logic                 req_i,
    input  logic [PlenWidth-1:0] req_paddr_i,
    input  logic                 req_nc_i,
    input  logic [TidWidth-1:0]  req_tid_i,
    output logic                 ack_o,

    input  logic                 flush_i,

    output logic                 ar_valid_o,
    input  logic                 ar_ready_i,
    output logic [63:0]          ar_addr_o,
    output logic [7:0]           ar_len_o,
    output logic [2:0]           ar_size_o,
    output logic [1:0]           ar_id_o,

    input  logic                 r_valid_i,
    output logic                 r_ready_o,
    input  logic [DataWidth-1:0] r_data_i,
    input  logic [1:0]           r_id_i,
    input  logic                 r_last_i,
    input  logic [1:0]           r_resp_i,

    output logic                 rtrn_vld_o,
    output logic [LineWidth-1:0] rtrn_data_o,
    output logic [TidWidth-1:0]  rtrn_tid_o,
    output logic                 rtrn_err_o,
    output logic                 busy_o
);

    localparam int unsigned Beats    = LineWidth / DataWidth;
    localparam int unsigned CntWidth = (Beats > 1) ? $clog2(Beats) : 1;
    localparam logic [CntWidth-1:0] CntMax = CntWidth'(Beats - 1);
    localparam logic [63:0] LineMask = ~(64'(LineWidth / 8) - 64'd1);
    localparam logic [63:0] WordMask = ~(64'(DataWidth / 8) - 64'd1);

    logic [NumSlots-1:0]  occ_q, nc_q, killed_q, err_q;
    logic [TidWidth-1:0]  tid_q  [NumSlots];
    logic [CntWidth-1:0]  cnt_q  [NumSlots];
    logic [LineWidth-1:0] line_q [NumSlots];
    logic [LineWidth-1:0] line_d [NumSlots];
    logic [NumSlots-1:0]  hit;
    logic                 free_any;
    logic [1:0]           free_idx;
    logic [63:0]          paddr_ext;
    logic                 unused_resp;

    assign unused_resp = r_resp_i[0];
    assign paddr_ext   = 64'(req_paddr_i);
    assign r_ready_o   = 1'b1;
    assign ar_size_o   = 3'($clog2(DataWidth / 8));
    assign busy_o      = |occ_q;
    assign ack_o       = req_i & free_any & (~ar_valid_o | ar_ready_i);

    always_comb begin
        free_any = 1'b0;
        free_idx = '0;
        for (int unsigned s = NumSlots; s > 0; s--) begin
            if (!occ_q[s-1]) begin
                free_any = 1'b1;
                free_idx = 2'(s - 1);
            end
        end
    end

    // Line as it looks with the current beat merged in; also the returned line on last.
    always_comb begin
        for (int unsigned s = 0; s < NumSlots; s++) begin
            hit[s]    = r_valid_i && (r_id_i == 2'(s)) && occ_q[s];
            line_d[s] = line_q[s];
            if (nc_q[s]) begin
                line_d[s] = LineWidth'(r_data_i);
            end else begin
                line_d[s][cnt_q[s]*DataWidth +: DataWidth] = r_data_i;
            end
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            occ_q       <= '0;
            nc_q        <= '0;
            killed_q    <= '0;
            err_q       <= '0;
            for (int unsigned s = 0; s < NumSlots; s++) begin
                tid_q[s]  <= '0;
                cnt_q[s]  <= '0;
                line_q[s] <= '0;
            end
            ar_valid_o  <= 1'b0;
            ar_addr_o   <= '0;
            ar_len_o    <= '0;
            ar_id_o     <= '0;
            rtrn_vld_o  <= 1'b0;
            rtrn_data_o <= '0;
            rtrn_tid_o  <= '0;
            rtrn_err_o  <= 1'b0;
        end else begin
            rtrn_vld_o <= 1'b0;
            if (ar_valid_o && ar_ready_i) begin
                ar_valid_o <= 1'b0;
            end
            if (flush_i) begin
                killed_q <= killed_q | occ_q;
            end
            if (ack_o) begin
                ar_valid_o <= 1'b1;
                ar_id_o    <= free_idx;
                ar_addr_o  <= paddr_ext & (req_nc_i ? WordMask : LineMask);
                ar_len_o   <= req_nc_i ? 8'd0 : 8'(Beats - 1);
            end
            for (int unsigned s = 0; s < NumSlots; s++) begin
                if (hit[s]) begin
                    line_q[s] <= line_d[s];
                    if (!nc_q[s] && cnt_q[s] != CntMax) begin
                        cnt_q[s] <= cnt_q[s] + 1'b1;
                    end
                    if (r_resp_i[1]) begin
                        err_q[s] <= 1'b1;
                    end
                    if (r_last_i) begin
                        occ_q[s] <= 1'b0;
                        if (!killed_q[s]) begin
                            rtrn_vld_o  <= 1'b1;
                            rtrn_data_o <= line_d[s];
                            rtrn_tid_o  <= tid_q[s];
                            rtrn_err_o  <= err_q[s] | r_resp_i[1];
                        end
                    end
                end
                // A flush in the allocation cycle must not kill the new slot.
                if (ack_o && free_idx == 2'(s)) begin
                    occ_q[s]    <= 1'b1;
                    nc_q[s]     <= req_nc_i;
                    killed_q[s] <= 1'b0;
                    err_q[s]    <= 1'b0;
                    tid_q[s]    <= req_tid_i;
                    cnt_q[s]    <= '0;
                    line_q[s]   <= '0;
                end
            end
        end
    end

endmodule
